xbar_slave_arbiter: RTL and testbench
=====================================

XBAR_SLAVE_ARBITER -- requirements
Module: xbar_slave_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning GRANT-state cycles without slave_ack before abort (used only with ARB_TIMEOUT_EN).
REQ-002 SHALL have parameter ERR_DATA, default 32'hDEAD_BEEF, meaning the rdata value returned on a timeout abort.
REQ-003 SHALL have port clk  in  1  the single clock; all logic on posedge.
REQ-004 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-005 SHALL have ports master_1_req / master_2_req  in  1  transfer request; held until the matching ack.
REQ-006 SHALL have ports master_1_addr / master_2_addr  in  32  word address.
REQ-007 SHALL have ports master_1_cmd / master_2_cmd  in  1  1 = write, 0 = read.
REQ-008 SHALL have ports master_1_wdata / master_2_wdata  in  32  write data.
REQ-009 SHALL have ports master_1_ack / master_2_ack  out  1  one-cycle completion pulse.
REQ-010 SHALL have ports master_1_rdata / master_2_rdata  out  32  read data, valid in the ack cycle.
REQ-011 SHALL have ports slave_req out 1, slave_addr out 32, slave_cmd out 1, slave_wdata out 32, all driven toward one slave RAM.
REQ-012 SHALL have ports slave_ack in 1 and slave_rdata in 32; slave read data is valid in the cycle after the slave_ack pulse.
REQ-013 SHALL have port timeout_err  out  1  one-cycle pulse marking an aborted transfer.

Function
REQ-014 SHALL implement an FSM with states IDLE, GRANT, RDATA and RESP, all outputs registered.
REQ-015 IDLE: when any master_x_req=1, SHALL latch the winner's addr/cmd/wdata, record the winner, and enter GRANT.
REQ-016 Arbitration SHALL be round-robin: on simultaneous requests the master not served last wins; a single requester always wins.
REQ-017 GRANT: slave_req SHALL be 1 with the latched fields stable until slave_ack=1.
REQ-018 GRANT with slave_ack=1 and cmd=1 SHALL drop slave_req next cycle, pulse the winner's ack with rdata=0, and enter RESP.
REQ-019 GRANT with slave_ack=1 and cmd=0 SHALL keep slave_req=1 for one more cycle and enter RDATA.
REQ-020 RDATA SHALL capture slave_rdata into the winner's rdata, drop slave_req, pulse the winner's ack, and enter RESP.
REQ-021 RESP SHALL clear the ack and return to IDLE; minimum request-to-ack latency is 2 cycles for writes and 3 cycles for reads when slave_ack arrives on the first GRANT cycle.
REQ-022 slave_ack seen outside GRANT (spurious or re-fired) SHALL be ignored.
REQ-023 The non-winning master's ack SHALL stay 0, and its rdata SHALL hold its last value.
REQ-024 A master SHALL drop req on the clock edge that samples its ack; a req still high in IDLE is treated as a new request.
REQ-025 Request inputs SHALL be ignored outside IDLE; a master whose request is not granted waits with no bound other than round-robin fairness (at most one transfer).

Reset
REQ-026 rst=1 at a clock edge SHALL force state to IDLE and set slave_req, both acks and timeout_err to 0; all rdata, slave_addr and slave_wdata to 0; slave_cmd to 0; and the round-robin pointer to "master_2 last served".
REQ-027 Reset mid-transfer SHALL abandon the transfer with no ack issued; late slave_ack or slave_rdata SHALL be ignored.

Configuration
REQ-028 With macro ARB_TIMEOUT_EN defined, a counter SHALL count GRANT cycles; at TIMEOUT_CYCLES without slave_ack the block SHALL drop slave_req, pulse the winner's ack with rdata=ERR_DATA and timeout_err=1 for one cycle, then enter RESP.
REQ-029 Without ARB_TIMEOUT_EN, GRANT SHALL wait indefinitely, no counter SHALL be built, and timeout_err SHALL be tied to 0.

Verification
REQ-030 Master_1 writes addr 0x05 with data 0x1234; slave acks on the 1st GRANT cycle -> slave_wdata=0x1234, master_1_ack pulses 2 cycles after req, master_2_ack=0.
REQ-031 Master_2 reads addr 0x05; slave_rdata=0x1234 in the cycle after slave_ack -> master_2_rdata=0x1234 in the master_2_ack cycle.
REQ-032 Both masters request in the same cycle, held continuously, after reset -> grants alternate 1,2,1,2 over 4 transfers.
REQ-033 Slave re-pulses slave_ack during RDATA -> exactly one master ack; the next transfer is unaffected.
REQ-034 rst asserted during GRANT while slave_ack arrives the following cycle -> no master ack, state returns to IDLE, and all outputs are at reset values.
REQ-035 With ARB_TIMEOUT_EN defined and TIMEOUT_CYCLES=16, slave never acks -> at the 16th GRANT cycle slave_req drops, ack pulses with rdata=0xDEADBEEF and timeout_err=1.

Source files
------------

// File: rtl/xbar_slave_arbiter_if.sv
// ============================================================================
// Module   : xbar_slave_arbiter_if
// Brief    : Two-master / one-slave bus bundle for xbar_slave_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface xbar_slave_arbiter_if;
    logic        master_1_req;
    logic        master_2_req;
    logic [31:0] master_1_addr;
    logic [31:0] master_2_addr;
    logic        master_1_cmd;
    logic        master_2_cmd;
    logic [31:0] master_1_wdata;
    logic [31:0] master_2_wdata;
    logic        master_1_ack;
    logic        master_2_ack;
    logic [31:0] master_1_rdata;
    logic [31:0] master_2_rdata;

    logic        slave_req;
    logic [31:0] slave_addr;
    logic        slave_cmd;
    logic [31:0] slave_wdata;
    logic        slave_ack;
    logic [31:0] slave_rdata;

    logic        timeout_err;

    // Arbiter view: serves both masters, drives the slave RAM.
    modport slave (
        input  master_1_req, master_2_req, master_1_addr, master_2_addr,
        input  master_1_cmd, master_2_cmd, master_1_wdata, master_2_wdata,
        output master_1_ack, master_2_ack, master_1_rdata, master_2_rdata,
        output slave_req, slave_addr, slave_cmd, slave_wdata,
        input  slave_ack, slave_rdata,
        output timeout_err
    );

    // Environment view: the two masters plus the slave RAM.
    modport master (
        output master_1_req, master_2_req, master_1_addr, master_2_addr,
        output master_1_cmd, master_2_cmd, master_1_wdata, master_2_wdata,
        input  master_1_ack, master_2_ack, master_1_rdata, master_2_rdata,
        input  slave_req, slave_addr, slave_cmd, slave_wdata,
        output slave_ack, slave_rdata,
        input  timeout_err
    );
endinterface

`default_nettype wire

// File: rtl/xbar_slave_arbiter.sv
// ============================================================================
// Module   : xbar_slave_arbiter
// Brief    : Round-robin arbiter giving two masters access to one slave RAM.
//            Optional GRANT timeout abort enabled by macro ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module xbar_slave_arbiter #(
    parameter int          TIMEOUT_CYCLES = 16,
    parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
    input  logic                 clk,
    input  logic                 rst,
    xbar_slave_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        RDATA = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state_q;
    logic        last2_q;     // 1: master_2 was served last
    logic        win2_q;      // 1: master_2 owns the current transfer
    logic        slave_req_q;
    logic        slave_cmd_q;
    logic [31:0] slave_addr_q;
    logic [31:0] slave_wdata_q;
    logic        m1_ack_q;
    logic        m2_ack_q;
    logic [31:0] m1_rdata_q;
    logic [31:0] m2_rdata_q;
    logic        grant2;
    logic        expire;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("xbar_slave_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    // master_2 wins when alone, or when both ask and master_1 went last.
    assign grant2 = bus.master_2_req & (~bus.master_1_req | ~last2_q);

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             timeout_q;

    always_ff @(posedge clk) begin
        if (rst || state_q != GRANT) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expire          = (state_q == GRANT) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign bus.timeout_err = timeout_q;
`else
    assign expire          = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            last2_q       <= 1'b1;
            win2_q        <= 1'b0;
            slave_req_q   <= 1'b0;
            slave_cmd_q   <= 1'b0;
            slave_addr_q  <= '0;
            slave_wdata_q <= '0;
            m1_ack_q      <= 1'b0;
            m2_ack_q      <= 1'b0;
            m1_rdata_q    <= '0;
            m2_rdata_q    <= '0;
`ifdef ARB_TIMEOUT_EN
            timeout_q     <= 1'b0;
`endif
        end else begin
            m1_ack_q <= 1'b0;
            m2_ack_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (bus.master_1_req || bus.master_2_req) begin
                        win2_q        <= grant2;
                        last2_q       <= grant2;
                        slave_req_q   <= 1'b1;
                        slave_addr_q  <= grant2 ? bus.master_2_addr  : bus.master_1_addr;
                        slave_cmd_q   <= grant2 ? bus.master_2_cmd   : bus.master_1_cmd;
                        slave_wdata_q <= grant2 ? bus.master_2_wdata : bus.master_1_wdata;
                        state_q       <= GRANT;
                    end
                end
                GRANT: begin
                    if (bus.slave_ack) begin
                        if (slave_cmd_q) begin
                            slave_req_q <= 1'b0;
                            m1_ack_q    <= ~win2_q;
                            m2_ack_q    <= win2_q;
                            if (win2_q) m2_rdata_q <= '0;
                            else        m1_rdata_q <= '0;
                            state_q     <= RESP;
                        end else begin
                            state_q     <= RDATA;
                        end
                    end else if (expire) begin
                        slave_req_q <= 1'b0;
                        m1_ack_q    <= ~win2_q;
                        m2_ack_q    <= win2_q;
                        if (win2_q) m2_rdata_q <= ERR_DATA;
                        else        m1_rdata_q <= ERR_DATA;
`ifdef ARB_TIMEOUT_EN
                        timeout_q   <= 1'b1;
`endif
                        state_q     <= RESP;
                    end
                end
                RDATA: begin
                    // Slave data lags its ack by one cycle; any ack seen here is ignored.
                    slave_req_q <= 1'b0;
                    m1_ack_q    <= ~win2_q;
                    m2_ack_q    <= win2_q;
                    if (win2_q) m2_rdata_q <= bus.slave_rdata;
                    else        m1_rdata_q <= bus.slave_rdata;
                    state_q     <= RESP;
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.slave_req      = slave_req_q;
    assign bus.slave_addr     = slave_addr_q;
    assign bus.slave_cmd      = slave_cmd_q;
    assign bus.slave_wdata    = slave_wdata_q;
    assign bus.master_1_ack   = m1_ack_q;
    assign bus.master_2_ack   = m2_ack_q;
    assign bus.master_1_rdata = m1_rdata_q;
    assign bus.master_2_rdata = m2_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_xbar_slave_arbiter.sv
// ============================================================================
// Module   : tb_xbar_slave_arbiter
// Brief    : Scoreboard bench for xbar_slave_arbiter with a behavioural slave RAM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_xbar_slave_arbiter;

    logic clk = 1'b0;
    logic rst;

    xbar_slave_arbiter_if bus();

    xbar_slave_arbiter #(
        .TIMEOUT_CYCLES (16),
        .ERR_DATA       (32'hDEAD_BEEF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] rdata;
        logic        terr;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic expect_ack(input int id, input logic [31:0] rd, input logic te);
        exp_t e;
        e.id = id; e.rdata = rd; e.terr = te;
        sb.push_back(e);
    endtask

    // ---------------- slave RAM model ----------------
    int          ack_wait = 0;
    bit          repulse  = 0;
    bit          inj_ack  = 0;
    logic [31:0] mem [16];
    logic [31:0] wr_addr_seen = '0;
    logic [31:0] wr_data_seen = '0;
    int          gcnt     = 0;
    bit          acked    = 0;
    bit          prev_rd  = 0;
    logic [3:0]  rd_addr  = '0;

    initial begin
        bit ack_now;
        bus.slave_ack   = 1'b0;
        bus.slave_rdata = 32'hBAD0_0BAD;
        forever begin
            @(posedge clk); #1;
            ack_now         = 1'b0;
            bus.slave_rdata = 32'hBAD0_0BAD;
            if (prev_rd) begin
                bus.slave_rdata = mem[rd_addr];
                ack_now         = repulse;
            end
            prev_rd = 0;
            if (!bus.slave_req) begin
                gcnt  = 0;
                acked = 0;
            end else if (!acked) begin
                if (gcnt == ack_wait) begin
                    ack_now = 1'b1;
                    acked   = 1;
                    if (bus.slave_cmd) begin
                        mem[bus.slave_addr[3:0]] = bus.slave_wdata;
                        wr_addr_seen = bus.slave_addr;
                        wr_data_seen = bus.slave_wdata;
                    end else begin
                        prev_rd = 1;
                        rd_addr = bus.slave_addr[3:0];
                    end
                end else begin
                    gcnt++;
                end
            end
            bus.slave_ack = ack_now | inj_ack;
        end
    end

    // ---------------- ack monitor ----------------
    always @(negedge clk) begin
        if (!rst && (bus.master_1_ack || bus.master_2_ack)) begin
            exp_t e;
            check_eq("ack_onehot", {31'b0, bus.master_1_ack & bus.master_2_ack}, 32'd0);
            check_eq("slave_req_at_ack", {31'b0, bus.slave_req}, 32'd0);
            check_eq("sb_nonempty", {31'b0, (sb.size() != 0)}, 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check_eq("ack_id", bus.master_1_ack ? 32'd1 : 32'd2, e.id);
                check_eq("ack_rdata", bus.master_1_ack ? bus.master_1_rdata : bus.master_2_rdata, e.rdata);
                check_eq("timeout_err", {31'b0, bus.timeout_err}, {31'b0, e.terr});
            end
        end
        if (bus.timeout_err) begin
            check_eq("terr_with_ack", {31'b0, bus.master_1_ack | bus.master_2_ack}, 32'd1);
        end
    end

    // ---------------- master driver ----------------
    task automatic set_m(input int m, input logic r, input logic c,
                         input logic [31:0] a, input logic [31:0] d);
        if (m == 1) begin
            bus.master_1_req = r; bus.master_1_cmd = c;
            bus.master_1_addr = a; bus.master_1_wdata = d;
        end else begin
            bus.master_2_req = r; bus.master_2_cmd = c;
            bus.master_2_addr = a; bus.master_2_wdata = d;
        end
    endtask

    function automatic logic ack_of(input int m);
        return (m == 1) ? bus.master_1_ack : bus.master_2_ack;
    endfunction

    // Call at posedge+#1; returns at posedge+#1 after the edge that samples the ack.
    task automatic master_xfer(input int m, input logic cmd, input logic [31:0] addr,
                               input logic [31:0] wdata, input int exp_lat);
        int lat = 0;
        set_m(m, 1'b1, cmd, addr, wdata);
        @(negedge clk);
        while (!ack_of(m) && lat < 300) begin
            lat++;
            @(negedge clk);
        end
        if (!ack_of(m)) begin
            check_eq("ack_wait_bound", 32'd0, 32'd1);
        end else if (exp_lat >= 0) begin
            check_eq("ack_latency", lat, exp_lat);
        end
        @(posedge clk); #1;
        set_m(m, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        int k;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        set_m(1, 1'b0, 1'b0, '0, '0);
        set_m(2, 1'b0, 1'b0, '0, '0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_slave_req",   {31'b0, bus.slave_req},   32'd0);
        check_eq("rst_m1_ack",      {31'b0, bus.master_1_ack}, 32'd0);
        check_eq("rst_m2_ack",      {31'b0, bus.master_2_ack}, 32'd0);
        check_eq("rst_m1_rdata",    bus.master_1_rdata, 32'd0);
        check_eq("rst_m2_rdata",    bus.master_2_rdata, 32'd0);
        check_eq("rst_slave_addr",  bus.slave_addr,  32'd0);
        check_eq("rst_slave_wdata", bus.slave_wdata, 32'd0);
        check_eq("rst_slave_cmd",   {31'b0, bus.slave_cmd},   32'd0);
        check_eq("rst_timeout_err", {31'b0, bus.timeout_err}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single-master write then read-back, slave acks on first GRANT cycle
        ack_wait = 0;
        expect_ack(1, 32'h0, 1'b0);
        master_xfer(1, 1'b1, 32'h5, 32'h1234, 2);
        check_eq("wr_addr", wr_addr_seen, 32'h5);
        check_eq("wr_data", wr_data_seen, 32'h1234);
        expect_ack(2, 32'h1234, 1'b0);
        master_xfer(2, 1'b0, 32'h5, 32'h0, 3);

        expect_ack(2, 32'h0, 1'b0);
        master_xfer(2, 1'b1, 32'h7, 32'hA5A5_0007, 2);
        expect_ack(1, 32'hA5A5_0007, 1'b0);
        master_xfer(1, 1'b0, 32'h7, 32'h0, 3);
        check_eq("m2_rdata_after_write", bus.master_2_rdata, 32'h0);

        // Delayed slave ack; idle master's rdata must hold
        ack_wait = 3;
        expect_ack(2, 32'h0, 1'b0);
        master_xfer(2, 1'b1, 32'h9, 32'h0000_0099, 5);
        check_eq("m1_rdata_hold", bus.master_1_rdata, 32'hA5A5_0007);

        // Slave re-fires ack during RDATA: one master ack, next transfer unaffected
        ack_wait = 0;
        repulse  = 1;
        expect_ack(1, 32'h1234, 1'b0);
        master_xfer(1, 1'b0, 32'h5, 32'h0, 3);
        repulse  = 0;
        expect_ack(2, 32'h99, 1'b0);
        master_xfer(2, 1'b0, 32'h9, 32'h0, 3);

        // Reset during GRANT with a late slave ack one cycle later
        ack_wait = 1000;
        set_m(1, 1'b1, 1'b0, 32'h5, 32'h0);
        k = 0;
        @(negedge clk);
        while (!bus.slave_req && k < 10) begin
            k++;
            @(negedge clk);
        end
        check_eq("grant_seen", {31'b0, bus.slave_req}, 32'd1);
        rst     = 1'b1;
        inj_ack = 1'b1;
        set_m(1, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check_eq("mid_rst_slave_req", {31'b0, bus.slave_req}, 32'd0);
        check_eq("mid_rst_m1_ack",    {31'b0, bus.master_1_ack}, 32'd0);
        check_eq("mid_rst_m1_rdata",  bus.master_1_rdata, 32'd0);
        check_eq("mid_rst_m2_rdata",  bus.master_2_rdata, 32'd0);
        check_eq("mid_rst_addr",      bus.slave_addr, 32'd0);
        check_eq("mid_rst_cmd",       {31'b0, bus.slave_cmd}, 32'd0);
        rst     = 1'b0;
        inj_ack = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("post_rst_idle", {31'b0, bus.slave_req}, 32'd0);
        check_eq("post_rst_m1_ack", {31'b0, bus.master_1_ack}, 32'd0);
        @(posedge clk); #1;

        // Both masters held from reset: grants alternate 1,2,1,2
        ack_wait = 0;
        expect_ack(1, 32'h0, 1'b0);
        expect_ack(2, 32'h99, 1'b0);
        expect_ack(1, 32'h11, 1'b0);
        expect_ack(2, 32'h0, 1'b0);
        fork
            begin
                master_xfer(1, 1'b1, 32'h1, 32'h11, -1);
                master_xfer(1, 1'b0, 32'h1, 32'h0, -1);
            end
            begin
                master_xfer(2, 1'b0, 32'h9, 32'h0, -1);
                master_xfer(2, 1'b1, 32'h2, 32'h22, -1);
            end
        join
        check_eq("rr_wr_addr", wr_addr_seen, 32'h2);
        check_eq("rr_wr_data", wr_data_seen, 32'h22);

`ifdef ARB_TIMEOUT_EN
        // Slave never answers: abort on the 16th GRANT cycle
        ack_wait = 100000;
        expect_ack(1, 32'hDEAD_BEEF, 1'b1);
        master_xfer(1, 1'b0, 32'h3, 32'h0, 17);
        ack_wait = 0;
        expect_ack(2, 32'h1234, 1'b0);
        master_xfer(2, 1'b0, 32'h5, 32'h0, 3);
`else
        // Without the timeout a slow slave is simply waited for
        ack_wait = 20;
        expect_ack(2, 32'h0, 1'b0);
        master_xfer(2, 1'b1, 32'h4, 32'h44, 22);
        check_eq("slow_wr_data", wr_data_seen, 32'h44);
`endif

        repeat (4) @(negedge clk);
        check_eq("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
